// File: rtl/daq_sched_pkg.sv
// Shared types and helpers for the DAQ acquisition scheduler.
package daq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    CONV      = 2'd2,
    DONE      = 2'd3
  } sched_state_e;

  // A single-channel build still needs a 1-bit ch_sel port.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/daq_prescaler.sv
// Runtime-programmable modulo counter; tick marks the last count of each period.
module daq_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == div - DIV_W'(1));
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/daq_acq_scheduler.sv
// Frame sequencer: sample ticks from a programmable prescaler launch a
// round-robin pass of start/ready conversions over all channels.
//
// state     | meaning
// IDLE      | no frame; waiting for start
// WAIT_TICK | frame running, waiting for the next sample tick
// CONV      | converting channels 0..NUM_CH-1 for the current sample
// DONE      | one-cycle done pulse, then back to IDLE
module daq_acq_scheduler
  import daq_sched_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16,
  parameter int NSAMP_W = 12,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [NSAMP_W-1:0] cfg_nsamp,
  input  logic               start,
  input  logic               abort,
  input  logic               adc_ready,
  output logic               busy,
  output logic               done,
  output logic               conv_start,
  output logic [CH_W-1:0]    ch_sel,
  output logic [NSAMP_W-1:0] sample_idx,
  output logic               overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  sched_state_e       state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [NSAMP_W-1:0] nsamp_q, nsamp_d;
  logic [NSAMP_W-1:0] samp_q, samp_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               conv_start_q, conv_start_d;
  logic               pend_q, pend_d;
  logic               overrun_q, overrun_d;
  logic               start_ok;
  logic               tick;

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign conv_start = conv_start_q;
  assign ch_sel     = ch_q;
  assign sample_idx = samp_q;
  assign overrun    = overrun_q;
  assign start_ok   = (state_q == IDLE) && start && !abort;

  daq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (start_ok),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    nsamp_d      = nsamp_q;
    samp_d       = samp_q;
    ch_d         = ch_q;
    conv_start_d = 1'b0;
    pend_d       = pend_q;
    overrun_d    = overrun_q;

    if (abort) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            div_d     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
            nsamp_d   = cfg_nsamp;
            samp_d    = '0;
            ch_d      = '0;
            overrun_d = 1'b0;
            state_d   = (cfg_nsamp == '0) ? DONE : WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (tick) begin
            state_d      = CONV;
            ch_d         = '0;
            conv_start_d = 1'b1;
          end
        end
        CONV: begin
          // A tick here has no slot to run in; it is dropped and flagged.
          if (tick) overrun_d = 1'b1;
          if (conv_start_q) pend_d = 1'b1;
          if (pend_q && adc_ready) begin
            pend_d = 1'b0;
            if (ch_q != LAST_CH) begin
              ch_d         = ch_q + CH_W'(1);
              conv_start_d = 1'b1;
            end else if (samp_q == nsamp_q - NSAMP_W'(1)) begin
              state_d = DONE;
            end else begin
              samp_d  = samp_q + NSAMP_W'(1);
              ch_d    = '0;
              state_d = WAIT_TICK;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= DIV_W'(1);
      nsamp_q      <= '0;
      samp_q       <= '0;
      ch_q         <= '0;
      conv_start_q <= 1'b0;
      pend_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      nsamp_q      <= nsamp_d;
      samp_q       <= samp_d;
      ch_q         <= ch_d;
      conv_start_q <= conv_start_d;
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
